pc_fetch_reg: RTL and testbench

- Program-counter register and instruction-fetch sequencer.
- Sits directly downstream of the branch mux: it registers the mux's selected next PC and fetches one instruction per PC from instruction memory over a req/ack handshake.
- It produces the fall-through PC (current PC + step) that feeds back into the branch mux's pcoutput input.
- Non-pipelined: exactly one instruction is held and presented at a time.

---
 rtl/pc_fetch_reg.sv | 128 ++++++++++++
 tb/tb_pc_fetch_reg.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_reg.sv
// -----------------------------------------------------------------------------
// pc_fetch_reg
//
// Program-counter register and single-instruction fetch sequencer. It sits
// directly after the branch mux: it holds the current PC, fetches the word at
// that PC over a req/ack handshake, presents it until downstream consumes it,
// then loads the next PC selected by the mux. Only one instruction is ever in
// flight or held.
//
// Parameters
//   w         datapath width of PC, addresses and instruction words
//   RESET_PC  PC loaded on reset (4-byte aligned)
//   PC_STEP   increment used to form the fall-through PC
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   pc_mux_out    next PC from the branch mux, sampled only on consume
//   stall         downstream not ready; the held instruction is kept
//   imem_ack      memory returns imem_rdata for the outstanding request
//   imem_rdata    instruction word, valid with imem_ack
//   imem_req      fetch request (registered)
//   imem_addr     fetch address, always equal to pc
//   pc            current PC register
//   pcoutput      pc + PC_STEP (wraps), fed back to the branch mux
//   instr         last fetched instruction word
//   instr_valid   instr/pc hold a fetched, unconsumed instruction
//   retire_count  instructions consumed since reset (wraps)
//   misalign_err  sticky: a non-word-aligned next PC was received
// -----------------------------------------------------------------------------
module pc_fetch_reg #(
  parameter int unsigned     w        = 32,
  parameter logic [w-1:0]    RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [w-1:0] pc_mux_out,
  input  logic         stall,
  input  logic         imem_ack,
  input  logic [w-1:0] imem_rdata,
  output logic         imem_req,
  output logic [w-1:0] imem_addr,
  output logic [w-1:0] pc,
  output logic [w-1:0] pcoutput,
  output logic [w-1:0] instr,
  output logic         instr_valid,
  output logic [w-1:0] retire_count,
  output logic         misalign_err
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } state_t;

  state_t       state_reg;
  logic [w-1:0] pc_reg;
  logic [w-1:0] instr_reg;
  logic [w-1:0] retire_count_reg;
  logic         misalign_err_reg;
  logic         imem_req_reg;
  logic         instr_valid_reg;

  // Handshake flags are registered alongside the state so neither output has
  // a combinational path from imem_ack or stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= BOOT;
      pc_reg           <= RESET_PC;
      instr_reg        <= '0;
      retire_count_reg <= '0;
      misalign_err_reg <= 1'b0;
      imem_req_reg     <= 1'b0;
      instr_valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        // One quiet cycle after reset release before the first request.
        BOOT: begin
          state_reg    <= REQ;
          imem_req_reg <= 1'b1;
        end

        // Request and address stay stable until memory answers; no timeout.
        REQ: begin
          if (imem_ack) begin
            instr_reg       <= imem_rdata;
            instr_valid_reg <= 1'b1;
            imem_req_reg    <= 1'b0;
            state_reg       <= VALID;
          end
        end

        // Hold until consumed. On consume the next PC is forced to a word
        // boundary; a misaligned target is only flagged, fetch proceeds.
        VALID: begin
          if (!stall) begin
            pc_reg           <= {pc_mux_out[w-1:2], 2'b00};
            retire_count_reg <= retire_count_reg + w'(1);
            if (pc_mux_out[1:0] != 2'b00) begin
              misalign_err_reg <= 1'b1;
            end
            instr_valid_reg  <= 1'b0;
            imem_req_reg     <= 1'b1;
            state_reg        <= REQ;
          end
        end

        default: begin
          state_reg       <= BOOT;
          imem_req_reg    <= 1'b0;
          instr_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req     = imem_req_reg;
  assign instr_valid  = instr_valid_reg;
  assign pc           = pc_reg;
  assign imem_addr    = pc_reg;
  assign pcoutput     = pc_reg + w'(PC_STEP);
  assign instr        = instr_reg;
  assign retire_count = retire_count_reg;
  assign misalign_err = misalign_err_reg;

endmodule

// File: tb/tb_pc_fetch_reg.sv
module tb_pc_fetch_reg;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_mux_out;
  logic        stall;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pcoutput;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] retire_count;
  logic        misalign_err;

  // Second instance with a reset PC at the top of the address space.
  logic [31:0] pc_mux_out2;
  logic        stall2;
  logic        imem_ack2;
  logic [31:0] imem_rdata2;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic [31:0] pc2;
  logic [31:0] pcoutput2;
  logic [31:0] instr2;
  logic        instr_valid2;
  logic [31:0] retire_count2;
  logic        misalign_err2;

  pc_fetch_reg #(.w(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_mux_out(pc_mux_out), .stall(stall),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_req(imem_req),
    .imem_addr(imem_addr), .pc(pc), .pcoutput(pcoutput), .instr(instr),
    .instr_valid(instr_valid), .retire_count(retire_count),
    .misalign_err(misalign_err)
  );

  pc_fetch_reg #(.w(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .pc_mux_out(pc_mux_out2), .stall(stall2),
    .imem_ack(imem_ack2), .imem_rdata(imem_rdata2), .imem_req(imem_req2),
    .imem_addr(imem_addr2), .pc(pc2), .pcoutput(pcoutput2), .instr(instr2),
    .instr_valid(instr_valid2), .retire_count(retire_count2),
    .misalign_err(misalign_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Transaction-level reference: what the architectural state should be.
  logic [31:0] m_pc;
  logic [31:0] m_retire;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete fetch/consume transaction. Entered at a falling edge with
  // the DUT in BOOT or REQ; returns at the falling edge after the consume.
  task automatic fetch(input int lat, input int stl, input logic [31:0] nxt,
                       input logic [31:0] word);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", {31'b0, imem_req}, 32'd1);
    for (int i = 0; i < lat; i++) begin
      check("addr_wait", imem_addr, m_pc);
      check("req_hold", {31'b0, imem_req}, 32'd1);
      check("valid_low", {31'b0, instr_valid}, 32'd0);
      @(negedge clk);
    end
    check("addr", imem_addr, m_pc);
    check("pcoutput", pcoutput, m_pc + 32'd4);
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    check("valid_after_ack", {31'b0, instr_valid}, 32'd1);
    check("instr", instr, word);
    check("req_drop", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < stl; i++) begin
      stall      = 1'b1;
      pc_mux_out = $urandom;
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      @(negedge clk);
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_instr", instr, word);
      check("stall_pc", pc, m_pc);
      check("stall_retire", retire_count, m_retire);
      check("stall_noreq", {31'b0, imem_req}, 32'd0);
    end
    stall      = 1'b0;
    pc_mux_out = nxt;
    imem_ack   = 1'($urandom);
    imem_rdata = $urandom;
    @(negedge clk);
    imem_ack   = 1'b0;
    stall      = 1'($urandom);
    pc_mux_out = $urandom;
    m_pc     = nxt & 32'hFFFF_FFFC;
    m_retire = m_retire + 32'd1;
    m_err    = m_err | (nxt[1:0] != 2'b00);
    check("next_pc", pc, m_pc);
    check("retire", retire_count, m_retire);
    check("misalign", {31'b0, misalign_err}, {31'b0, m_err});
    check("consume_valid", {31'b0, instr_valid}, 32'd0);
    check("consume_req", {31'b0, imem_req}, 32'd1);
    check("instr_kept", instr, word);
    $display("fetch instr=%h next_pc=%h retire=%0d misalign=%0d", word, m_pc, m_retire, m_err);
  endtask

  initial begin
    logic [31:0] nxt;
    rst_n = 1'b0; pc_mux_out = '0; stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    pc_mux_out2 = '0; stall2 = 1'b1; imem_ack2 = 1'b0; imem_rdata2 = '0;
    m_pc = 32'h0; m_retire = 32'h0; m_err = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pc", pc, 32'h0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_retire", retire_count, 32'h0);
    check("rst_misalign", {31'b0, misalign_err}, 32'd0);

    // Release: one quiet BOOT cycle; an ack during BOOT is ignored.
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    #1 check("boot_quiet", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    imem_ack = 1'b0;
    check("boot_to_req", {31'b0, imem_req}, 32'd1);
    check("boot_ack_ignored", instr, 32'h0);
    check("boot_valid", {31'b0, instr_valid}, 32'd0);

    // Minimum latency, then sequential fetch with 2-cycle ack latency.
    fetch(0, 0, 32'h4, 32'h1111_0001);
    fetch(2, 0, 32'h8, 32'h1111_0002);
    fetch(2, 0, 32'hC, 32'h1111_0003);
    check("retire_three", retire_count, 32'd3);
    // Taken branch from 0xC to 0x40.
    fetch(2, 0, 32'h40, 32'h1111_0004);
    check("branch_addr", imem_addr, 32'h40);
    check("branch_pcoutput", pcoutput, 32'h44);
    // Three-cycle stall.
    fetch(0, 3, 32'h44, 32'h2222_0000);
    // Misaligned target 0x42 lands on 0x40 and sets the sticky flag.
    fetch(1, 0, 32'h42, 32'h3333_0000);
    check("misalign_pc", pc, 32'h40);
    check("misalign_set", {31'b0, misalign_err}, 32'd1);

    // Random transactions, some with misaligned targets.
    for (int t = 0; t < 24; t++) begin
      nxt = $urandom;
      if ($urandom_range(0, 1) == 0) nxt[1:0] = 2'b00;
      fetch($urandom_range(0, 3), $urandom_range(0, 2), nxt, $urandom);
    end
    check("misalign_sticky", {31'b0, misalign_err}, 32'd1);

    // Asynchronous reset in the middle of an unanswered request.
    @(negedge clk);
    check("pre_rst_req", {31'b0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", {31'b0, imem_req}, 32'd0);
    check("arst_pc", pc, 32'h0);
    check("arst_retire", retire_count, 32'h0);
    check("arst_misalign", {31'b0, misalign_err}, 32'd0);
    check("arst_instr", instr, 32'h0);
    m_pc = 32'h0; m_retire = 32'h0; m_err = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rerelease_quiet", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    fetch(1, 1, 32'h4, 32'h4444_0000);

    // Wrap instance: it has been waiting in REQ since the last release.
    check("wrap_pc", pc2, 32'hFFFF_FFFC);
    check("wrap_addr", imem_addr2, 32'hFFFF_FFFC);
    check("wrap_pcoutput", pcoutput2, 32'h0);
    check("wrap_req", {31'b0, imem_req2}, 32'd1);
    imem_ack2 = 1'b1; imem_rdata2 = 32'h5555_AAAA;
    @(negedge clk);
    imem_ack2 = 1'b0;
    check("wrap_valid", {31'b0, instr_valid2}, 32'd1);
    check("wrap_instr", instr2, 32'h5555_AAAA);
    stall2 = 1'b0; pc_mux_out2 = 32'h0;
    @(negedge clk);
    stall2 = 1'b1;
    check("wrap_next_pc", pc2, 32'h0);
    check("wrap_next_pcoutput", pcoutput2, 32'h4);
    check("wrap_retire", retire_count2, 32'd1);
    $display("wrap fetch instr=%h next_pc=%h", instr2, pc2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  // Absolute backstop against a hung handshake.
  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
